de2i_150_qsys_nios2_jtag_mem_access: RTL and testbench

Debug-memory access engine on the system-clock side of the Nios II JTAG debug module. It consumes the `jdo` payload and the `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes produced by the JTAG debug-module wrapper. It executes the corresponding read or write on a private synchronous debug RAM of 2^ADDR_W × 32 bits, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper for the next JTAG scan.

---
 rtl/de2i_150_qsys_nios2_jtag_mem_access.sv | 116 +++++++++++
 tb/tb_de2i_150_qsys_nios2_jtag_mem_access.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2i_150_qsys_nios2_jtag_mem_access.sv
// Nios II JTAG debug-memory access engine: runs ocimem reads and writes against a private debug RAM.
// Optional write protection of the top of the RAM is enabled with `JTAG_MEM_ACCESS_PROTECT_EN.
module de2i_150_qsys_nios2_jtag_mem_access #(
    parameter int unsigned ADDR_W       = 8,
    parameter logic [7:0]  PROTECT_BASE = 8'hE0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

`ifdef JTAG_MEM_ACCESS_PROTECT_EN
    localparam bit PROTECT_ON = 1'b1;
`else
    localparam bit PROTECT_ON = 1'b0;
`endif

    state_t            state, state_next;
    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] jdo_addr, rd_addr, areg_next;
    logic [31:0]       dreg_next;
    logic              ready_next, error_next, ram_we, ram_re;
    logic              any_strobe, multi_strobe, wr_blocked;
    logic [7:0]        areg_ext;
    logic              unused_jdo;

    assign jdo_addr     = jdo[10+ADDR_W-1:10];
    assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b)
                        | (take_action_ocimem_a & take_no_action_ocimem_a)
                        | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign areg_ext     = 8'(MonAReg);
    assign wr_blocked   = PROTECT_ON && (areg_ext >= PROTECT_BASE);
    assign unused_jdo   = ^{jdo[37:36], jdo[2:0]};

    always_comb begin
        state_next = state;
        areg_next  = MonAReg;
        dreg_next  = MonDReg;
        ready_next = monitor_ready;
        error_next = monitor_error;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        rd_addr    = MonAReg;
        if (state == RD_WAIT) begin
            // The read completes regardless; any strobe arriving now is illegal.
            dreg_next  = ram_q;
            areg_next  = MonAReg + ADDR_W'(1);
            ready_next = 1'b1;
            state_next = IDLE;
            if (any_strobe) error_next = 1'b1;
        end else if (any_strobe) begin
            if (!debugack) begin
                error_next = 1'b1;
            end else begin
                if (take_action_ocimem_a) begin
                    areg_next = jdo_addr;
                    if (jdo[34]) error_next = 1'b0;
                    if (jdo[35]) begin
                        ram_re     = 1'b1;
                        rd_addr    = jdo_addr;
                        state_next = RD_WAIT;
                        ready_next = 1'b0;
                    end else begin
                        ready_next = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    if (wr_blocked) error_next = 1'b1;
                    else            ram_we     = 1'b1;
                    areg_next  = MonAReg + ADDR_W'(1);
                    ready_next = 1'b1;
                end else begin
                    ram_re     = 1'b1;
                    state_next = RD_WAIT;
                    ready_next = 1'b0;
                end
                // Coincidence error is applied after any clear so it survives it.
                if (multi_strobe) error_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            state         <= state_next;
            MonAReg       <= areg_next;
            MonDReg       <= dreg_next;
            monitor_ready <= ready_next;
            monitor_error <= error_next;
        end
    end

    // RAM is intentionally not reset; writes are gated off while reset is asserted.
    always_ff @(posedge clk) begin
        if (ram_we && reset_n) mem[MonAReg] <= jdo[34:3];
        if (ram_re)            ram_q        <= mem[rd_addr];
    end

endmodule

// File: tb/tb_de2i_150_qsys_nios2_jtag_mem_access.sv
// Scoreboard bench for the JTAG debug-memory access engine: directed plan plus randomized commands.
module tb_de2i_150_qsys_nios2_jtag_mem_access;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int PBASE = 'hE0;
`ifdef JTAG_MEM_ACCESS_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [37:0]   jdo = '0;
    logic          sa = 1'b0, sb = 1'b0, sn = 1'b0;
    logic          debugack = 1'b0;
    logic [31:0]   MonDReg;
    logic [AW-1:0] MonAReg;
    logic          monitor_ready, monitor_error;

    de2i_150_qsys_nios2_jtag_mem_access #(.ADDR_W(AW), .PROTECT_BASE(8'hE0)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (sa),
        .take_action_ocimem_b    (sb),
        .take_no_action_ocimem_a (sn),
        .debugack                (debugack),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word-addressed memory plus the externally visible registers.
    logic [31:0] mm [DEPTH];
    bit          mk [DEPTH];
    int          m_areg;
    logic [31:0] m_dreg, m_pend;
    bit          m_dknown, m_pknown, m_rdy, m_err, m_busy;

    typedef struct {
        int          cyc;
        logic [31:0] dreg;
        int          areg;
        bit          rdy;
        bit          err;
        bit          dknown;
    } exp_t;
    exp_t exp_q[$];

    task automatic model_reset();
        m_areg = 0; m_dreg = '0; m_dknown = 1'b1;
        m_rdy = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_start_read();
        m_busy = 1'b1; m_pend = mm[m_areg]; m_pknown = mk[m_areg]; m_rdy = 1'b0;
    endtask

    task automatic model_step(bit a, bit b, bit n, logic [37:0] j, bit dack);
        int ns;
        bit was_busy;
        ns = int'(a) + int'(b) + int'(n);
        was_busy = m_busy;
        if (m_busy) begin
            m_dreg = m_pend; m_dknown = m_pknown;
            m_areg = (m_areg + 1) % DEPTH; m_rdy = 1'b1; m_busy = 1'b0;
        end
        if (ns > 0) begin
            if (was_busy || !dack) begin
                m_err = 1'b1;
            end else begin
                if (a) begin
                    m_areg = int'(j[10 +: AW]);
                    if (j[34]) m_err = 1'b0;
                    if (j[35]) model_start_read();
                    else       m_rdy = 1'b1;
                end else if (b) begin
                    if (PROT && m_areg >= PBASE) m_err = 1'b1;
                    else begin mm[m_areg] = j[34:3]; mk[m_areg] = 1'b1; end
                    m_areg = (m_areg + 1) % DEPTH;
                    m_rdy = 1'b1;
                end else begin
                    model_start_read();
                end
                if (ns > 1) m_err = 1'b1;
            end
        end
    endtask

    task automatic tick(bit a, bit b, bit n, logic [37:0] j, bit dack = 1'b1);
        exp_t e;
        sa = a; sb = b; sn = n; jdo = j; debugack = dack;
        @(posedge clk);
        #1;
        model_step(a, b, n, j, dack);
        e.cyc = cyc; e.dreg = m_dreg; e.areg = m_areg;
        e.rdy = m_rdy; e.err = m_err; e.dknown = m_dknown;
        exp_q.push_back(e);
        sa = 1'b0; sb = 1'b0; sn = 1'b0; debugack = 1'b1;
    endtask

    function automatic logic [37:0] cmd_a(int addr, bit rd, bit clr);
        logic [37:0] j;
        j = '0;
        j[10 +: AW] = addr[AW-1:0];
        j[35] = rd;
        j[34] = clr;
        return j;
    endfunction

    function automatic logic [37:0] cmd_b(logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_cycle", 32'(e.cyc), 32'(cyc));
            check("sb_areg", 32'(MonAReg), 32'(e.areg));
            check("sb_ready", 32'(monitor_ready), 32'(e.rdy));
            check("sb_error", 32'(monitor_error), 32'(e.err));
            if (e.dknown) check("sb_dreg", MonDReg, e.dreg);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [63:0] w;
        bit dack;
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dreg", MonDReg, 32'h0);
        check("rst_areg", 32'(MonAReg), 32'h0);
        check("rst_ready", 32'(monitor_ready), 32'h0);
        check("rst_error", 32'(monitor_error), 32'h0);
        reset_n = 1'b1;
        debugack = 1'b1;

        // Fill the RAM so every later read has a defined value.
        tick(1, 0, 0, cmd_a(0, 0, 1));
        for (int i = 0; i < DEPTH; i++) tick(0, 1, 0, cmd_b($urandom));
        tick(1, 0, 0, cmd_a(0, 0, 1));

        tick(1, 0, 0, cmd_a('h10, 0, 0));
        check("p1_areg", 32'(MonAReg), 32'h10);
        check("p1_ready", 32'(monitor_ready), 32'h1);
        tick(0, 1, 0, cmd_b(32'hDEADBEEF));
        check("p1_wr_areg", 32'(MonAReg), 32'h11);
        tick(1, 0, 0, cmd_a('h10, 1, 0));
        check("p1_rd_busy", 32'(monitor_ready), 32'h0);
        tick(0, 0, 0, '0);
        check("p1_rd_data", MonDReg, 32'hDEADBEEF);
        check("p1_rd_areg", 32'(MonAReg), 32'h11);

        tick(1, 0, 0, cmd_a('hFE, 0, 0));
        for (int i = 1; i <= 4; i++) tick(0, 1, 0, cmd_b(32'(i)));
        tick(1, 0, 0, cmd_a('hFE, 0, 0));
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, '0);
            tick(0, 0, 0, '0);
            check("p2_burst_data", MonDReg, 32'(i + 1));
            check("p2_burst_areg", 32'(MonAReg), 32'(('hFE + i + 1) % DEPTH));
        end

        tick(1, 0, 0, cmd_a('h10, 0, 1));
        tick(0, 0, 1, '0);
        tick(0, 0, 1, '0);
        check("p3_b2b_data", MonDReg, 32'hDEADBEEF);
        check("p3_b2b_error", 32'(monitor_error), 32'h1);
        check("p3_b2b_areg", 32'(MonAReg), 32'h11);
        tick(1, 0, 0, cmd_a('h30, 0, 1));
        check("p3_clear", 32'(monitor_error), 32'h0);

        tick(1, 0, 0, cmd_a('h20, 0, 0));
        tick(0, 1, 0, cmd_b(32'hAAAA5555));
        tick(1, 0, 0, cmd_a('h20, 0, 0));
        tick(0, 1, 0, cmd_b(32'h11111111), 1'b0);
        check("p4_nodbg_areg", 32'(MonAReg), 32'h20);
        check("p4_nodbg_error", 32'(monitor_error), 32'h1);
        tick(1, 0, 0, cmd_a('h20, 1, 1));
        tick(0, 0, 0, '0);
        check("p4_nodbg_data", MonDReg, 32'hAAAA5555);
        check("p4_error_clr", 32'(monitor_error), 32'h0);

        // Abort a read in flight with reset, then confirm the RAM kept its contents.
        tick(1, 0, 0, cmd_a('h20, 1, 0));
        #2;
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        check("p5_rst_dreg", MonDReg, 32'h0);
        check("p5_rst_areg", 32'(MonAReg), 32'h0);
        check("p5_rst_ready", 32'(monitor_ready), 32'h0);
        check("p5_rst_error", 32'(monitor_error), 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1, 0, 0, cmd_a('h20, 1, 0));
        tick(0, 0, 0, '0);
        check("p5_after_rst", MonDReg, 32'hAAAA5555);
        check("p5_after_areg", 32'(MonAReg), 32'h21);

        tick(1, 0, 0, cmd_a('hE0, 0, 1));
        tick(0, 1, 0, cmd_b(32'h12345678));
        check("p6_prot_error", 32'(monitor_error), 32'(PROT));
        check("p6_prot_areg", 32'(MonAReg), 32'hE1);
        tick(1, 0, 0, cmd_a('hE0, 1, 0));
        tick(0, 0, 0, '0);
        check("p6_written", 32'(MonDReg == 32'h12345678), 32'(!PROT));
        tick(1, 0, 0, cmd_a(0, 0, 1));

        for (int k = 0; k < 800; k++) begin
            r = int'($urandom_range(0, 11));
            w = {$urandom(), $urandom()};
            dack = ($urandom_range(0, 15) != 0);
            case (r)
                0, 1, 2: tick(0, 0, 0, w[37:0], dack);
                3, 4:    tick(1, 0, 0, w[37:0], dack);
                5, 6:    tick(0, 1, 0, w[37:0], dack);
                7, 8:    tick(0, 0, 1, w[37:0], dack);
                default: tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), w[37:0], dack);
            endcase
        end
        repeat (3) tick(0, 0, 0, '0);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
